// File: rtl/ls374_reader.sv
// Read port for an ls374 octal latch: enables its outputs, waits for the bus
// to settle, captures the value and hands it over with a four-phase ack.
module ls374_reader #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] bus_in,
    output logic             oe_n,
    output logic             rd_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic [7:0]       rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        ACK
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             oe_n_q, oe_n_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oe_n_q  <= 1'b1;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oe_n_q  <= oe_n_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // oe_n is a register so the latch outputs only turn on cleanly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oe_n_d  = oe_n_q;
        data_d  = data_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = DRIVE;
                    cnt_d   = SETTLE_C;
                    oe_n_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (!rd_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    oe_n_d  = 1'b1;
                end else if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    oe_n_d  = 1'b1;
                    data_d  = bus_in;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                oe_n_d = 1'b1;
                if (!rd_req) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    assign oe_n     = oe_n_q;
    assign rd_ack   = (state_q == ACK);
    assign busy     = (state_q != IDLE);
    assign data_out = data_q;
    assign rd_count = count_q;

endmodule

// File: tb/tb_ls374_reader.sv
// Bench for ls374_reader: per-cycle vector table, then scoreboarded reads
// and hand-written reset corner cases.
module tb_ls374_reader;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             rd_req;
    logic [WIDTH-1:0] bus_in;
    logic             oe_n;
    logic             rd_ack;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic [7:0]       rd_count;

    int checks = 0;
    int errors = 0;

    ls374_reader #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (rd_req),
        .bus_in  (bus_in),
        .oe_n    (oe_n),
        .rd_ack  (rd_ack),
        .data_out(data_out),
        .busy    (busy),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       req;
        logic [3:0] bus;
        logic       oe;
        logic       ack;
        logic       bsy;
        logic [3:0] data;
        logic [7:0] cnt;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] exp_data_q[$];
    logic [7:0] exp_cnt_q[$];
    logic [7:0] model_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_oe,
                           input logic e_ack, input logic e_bsy,
                           input logic [3:0] e_data, input logic [7:0] e_cnt);
        chk({tag, ".oe_n"}, 32'(oe_n), 32'(e_oe));
        chk({tag, ".rd_ack"}, 32'(rd_ack), 32'(e_ack));
        chk({tag, ".busy"}, 32'(busy), 32'(e_bsy));
        chk({tag, ".data_out"}, 32'(data_out), 32'(e_data));
        chk({tag, ".rd_count"}, 32'(rd_count), 32'(e_cnt));
    endtask

    // One full read through the scoreboard, then release rd_req.
    task automatic do_read(input logic [3:0] v);
        int n;
        bit got;
        logic [3:0] ed;
        logic [7:0] ec;
        model_cnt = model_cnt + 8'd1;
        exp_data_q.push_back(v);
        exp_cnt_q.push_back(model_cnt);
        bus_in = v;
        rd_req = 1'b1;
        n = 0;
        got = 0;
        while (n < 20 && !got) begin
            step();
            n++;
            if (rd_ack) got = 1;
            else if (oe_n !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL rd.oe_low: oe_n=%0b at step %0d", oe_n, n);
            end
        end
        chk("rd.ack_seen", 32'(got), 32'd1);
        chk("rd.latency", 32'(n), 32'(SETTLE + 1));
        ed = exp_data_q.pop_front();
        ec = exp_cnt_q.pop_front();
        chk("rd.data_out", 32'(data_out), 32'(ed));
        chk("rd.rd_count", 32'(rd_count), 32'(ec));
        chk("rd.oe_in_ack", 32'(oe_n), 32'd1);
        rd_req = 1'b0;
        step();
        chk("rd.ack_drop", 32'(rd_ack), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        rd_req = 1'b0;
        bus_in = '0;

        // rst req bus | oe ack busy data cnt
        tbl.push_back('{1, 0, 4'h0, 1, 0, 0, 4'h0, 8'd0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{0, 0, 4'h0, 1, 0, 0, 4'h0, 8'd0});
        tbl.push_back('{0, 1, 4'hA, 0, 0, 1, 4'h0, 8'd0});
        tbl.push_back('{0, 1, 4'hA, 0, 0, 1, 4'h0, 8'd0});
        tbl.push_back('{0, 1, 4'hA, 1, 1, 1, 4'hA, 8'd1});
        tbl.push_back('{0, 0, 4'hA, 1, 0, 0, 4'hA, 8'd1});
        tbl.push_back('{0, 1, 4'h5, 0, 0, 1, 4'hA, 8'd1});
        tbl.push_back('{0, 0, 4'h5, 1, 0, 0, 4'hA, 8'd1});
        tbl.push_back('{0, 0, 4'h5, 1, 0, 0, 4'hA, 8'd1});
        tbl.push_back('{0, 1, 4'hF, 0, 0, 1, 4'hA, 8'd1});
        tbl.push_back('{0, 1, 4'h3, 0, 0, 1, 4'hA, 8'd1});
        tbl.push_back('{0, 1, 4'h6, 1, 1, 1, 4'h6, 8'd2});
        tbl.push_back('{0, 1, 4'h9, 1, 1, 1, 4'h6, 8'd2});
        tbl.push_back('{0, 0, 4'h9, 1, 0, 0, 4'h6, 8'd2});
        tbl.push_back('{0, 0, 4'hC, 1, 0, 0, 4'h6, 8'd2});

        foreach (tbl[i]) begin
            reset  = tbl[i].rst;
            rd_req = tbl[i].req;
            bus_in = tbl[i].bus;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].oe, tbl[i].ack,
                    tbl[i].bsy, tbl[i].data, tbl[i].cnt);
        end

        reset  = 1'b1;
        rd_req = 1'b0;
        step();
        reset     = 1'b0;
        model_cnt = 8'd0;
        for (int i = 0; i < 16; i++) do_read(4'(i));
        while (model_cnt != 8'd255) do_read(4'(model_cnt));
        chk("wrap.pre", 32'(rd_count), 32'd255);
        do_read(4'h7);
        chk("wrap.zero", 32'(rd_count), 32'd0);

        // reset mid-DRIVE with rd_req held: fresh request after release
        reset  = 1'b1;
        rd_req = 1'b0;
        step();
        reset  = 1'b0;
        rd_req = 1'b1;
        bus_in = 4'hB;
        step();
        chk_all("rst_drv.start", 0, 0, 1, 4'h0, 8'd0);
        reset = 1'b1;
        step();
        chk_all("rst_drv.rst", 1, 0, 0, 4'h0, 8'd0);
        reset = 1'b0;
        step();
        chk_all("rst_drv.new", 0, 0, 1, 4'h0, 8'd0);
        step();
        chk_all("rst_drv.mid", 0, 0, 1, 4'h0, 8'd0);
        step();
        chk_all("rst_drv.cap", 1, 1, 1, 4'hB, 8'd1);

        // reset while in ACK: drop ack, clear data and count
        reset  = 1'b1;
        rd_req = 1'b0;
        step();
        chk_all("rst_ack", 1, 0, 0, 4'h0, 8'd0);
        reset = 1'b0;
        step();
        chk_all("rst_ack.idle", 1, 0, 0, 4'h0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ls374_reader.md
LS374_READER -- requirements
Module: ls374_reader

Interface
REQ-001 Parameter WIDTH, default 4: width of the latched data path read from the ls374 q outputs.
REQ-002 Parameter SETTLE, default 2: clock cycles oe_n is held low before the bus is sampled; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 rd_req  input  1  read request from the consumer; four-phase handshake with rd_ack.
REQ-006 bus_in  input  WIDTH  data bus connected to the ls374 q outputs; driven only while oe_n is low.
REQ-007 oe_n  output  1  active-low output enable driven to the ls374.
REQ-008 rd_ack  output  1  read acknowledge; data_out is valid while high.
REQ-009 data_out  output  WIDTH  last captured bus value.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 rd_count  output  8  number of completed reads; wraps modulo 256.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DRIVE and ACK.
REQ-013 IDLE: oe_n=1, rd_ack=0; when rd_req=1 at edge N, go to DRIVE, load the settle counter with SETTLE, and drive oe_n=0 from edge N.
REQ-014 DRIVE: oe_n=0; at each edge with rd_req=1, if the counter equals 1, capture bus_in into data_out and go to ACK; otherwise decrement the counter.
REQ-015 Latency: with rd_req held high, data_out SHALL update and rd_ack SHALL rise at edge N+SETTLE, and oe_n SHALL be low for exactly SETTLE cycles.
REQ-016 ACK: oe_n=1, rd_ack=1; hold both until rd_req=0 at an edge, then go to IDLE with rd_ack=0.
REQ-017 rd_count SHALL increment by 1 on the edge that enters ACK, wrapping from 255 to 0 with no other effect.
REQ-018 Abort: rd_req=0 at any edge in DRIVE SHALL return the FSM to IDLE with oe_n=1, and SHALL leave data_out and rd_count unchanged and rd_ack low.
REQ-019 data_out SHALL change only on entry to ACK and SHALL otherwise hold its value, including across aborts and while in IDLE.
REQ-020 Back-to-back reads: rd_req re-asserted at the edge after ACK exits SHALL start a new DRIVE phase; IDLE therefore lasts at least one cycle between reads.
REQ-021 Bus contention guard: oe_n SHALL never be low in IDLE or ACK, and SHALL be driven from a register so that it is glitch-free.
REQ-022 bus_in SHALL be sampled only at the capture edge defined in REQ-014; its value at all other times SHALL be ignored.

Reset
REQ-023 When reset=1 at an edge, the block SHALL set state=IDLE, oe_n=1, rd_ack=0, busy=0, data_out=0, rd_count=0, and clear the settle counter.
REQ-024 Reset SHALL take priority over rd_req; a reset asserted mid-DRIVE or mid-ACK SHALL release the bus (oe_n=1) at that same edge, with no capture and no count.
REQ-025 After reset deasserts, rd_req already high SHALL be treated as a new request at the first edge with reset=0.

Verification (WIDTH=4, SETTLE=2)
REQ-026 Reset, then hold rd_req=0 for 5 cycles -> oe_n=1, rd_ack=0, busy=0, data_out=0000, rd_count=0 throughout.
REQ-027 bus_in=1010, rd_req rises at edge N -> oe_n=0 for cycles N..N+1; at edge N+2: data_out=1010, rd_ack=1, oe_n=1, rd_count=1; drop rd_req -> rd_ack=0 at the next edge.
REQ-028 rd_req high at edge N, low at edge N+1 -> oe_n=1 from N+1, no rd_ack, data_out and rd_count unchanged.
REQ-029 Run 16 back-to-back reads with bus_in=i (i = 0..15) -> each data_out equals i, and rd_count steps 1..16.
REQ-030 Preload rd_count=255 via 255 reads, then complete one more read -> rd_count=0.
REQ-031 Reset asserted one cycle after rd_req rises -> at that edge oe_n=1, busy=0, data_out=0000; with rd_req still high, a fresh DRIVE starts at the first edge after reset deasserts.
